key_pulse_gen: RTL and testbench

Debounces a raw push-button on the EGO1 board and produces a single clean, active-low count strobe `x` for each accepted press. It sits directly upstream of the 3-bit negedge-clocked counter stage: `x` drives that stage's `x` input, and `rd` is shared with it. A one-cycle `press_pulse`, the debounced level and a wrapping press count are also exported for LEDs and debug.

---
 rtl/key_pkg.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/key_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_key_pulse_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the EGO1 push-button front end.
package key_pkg;

    // Debounce FSM encoding
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_fsm_e;

    // Width of the wrapping accepted-press counter
    localparam int PRESS_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, cleared to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rd,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk) begin
        if (!rd) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/key_pulse_gen.sv
// Push-button debouncer producing one active-low count strobe per accepted press,
// plus a one-cycle press pulse, the debounced level and a wrapping press count.
module key_pulse_gen
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PULSE_LEN       = 16,
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   rd,
    input  logic                   key_in,
    output logic                   x,
    output logic                   press_pulse,
    output logic                   key_state,
    output logic [PRESS_CNT_W-1:0] press_cnt
);

    localparam int               TMR_W           = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST        = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD        = TMR_W'(PULSE_LEN);
    // With a one-cycle debounce the first stable sample is already the last one
    localparam bit               ACCEPT_ON_ENTRY = (DEBOUNCE_CYCLES == 1);

    // The timer must be idle before another press can be accepted, otherwise
    // the downstream stage would miss a falling edge of x.
    if (PULSE_LEN < 1 || PULSE_LEN > DEBOUNCE_CYCLES) begin : g_bad_pulse_len
        $fatal(1, "key_pulse_gen: PULSE_LEN must be in 1..DEBOUNCE_CYCLES");
    end
    if ((64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $fatal(1, "key_pulse_gen: CNT_W too narrow for DEBOUNCE_CYCLES");
    end

    logic                   key_s;
    key_fsm_e               state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   accept_d;
    logic                   x_q;
    logic                   pulse_q;
    logic                   key_state_q;
    logic [PRESS_CNT_W-1:0] press_cnt_q;

    sync_2ff u_sync (
        .clk (clk),
        .rd  (rd),
        .d_i (key_in),
        .q_o (key_s)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    // Next-state logic: debounce FSM, stability counter and strobe timer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (key_s) begin
                    cnt_d = '0;
                    if (ACCEPT_ON_ENTRY) begin
                        state_d  = PRESSED;
                        accept_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_d  = PRESSED;
                        accept_d = 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!key_s) begin
                    cnt_d   = '0;
                    state_d = ACCEPT_ON_ENTRY ? IDLE : RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (key_s) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept_d) begin
            tmr_d = TMR_LOAD;
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - TMR_W'(1);
        end else begin
            tmr_d = '0;
        end
    end

    // State and registered outputs; x is a flop so the downstream clock is glitch-free
    always_ff @(posedge clk) begin
        if (!rd) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            tmr_q       <= '0;
            x_q         <= 1'b1;
            pulse_q     <= 1'b0;
            key_state_q <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            x_q         <= (tmr_d == '0);
            pulse_q     <= accept_d;
            key_state_q <= (state_d == PRESSED) || (state_d == RELEASE_WAIT);
            if (accept_d) begin
                press_cnt_q <= press_cnt_q + PRESS_CNT_W'(1);
            end
        end
    end

    assign x           = x_q;
    assign press_pulse = pulse_q;
    assign key_state   = key_state_q;
    assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// Bench for key_pulse_gen: a streak-counting reference model predicts acceptances
// into a scoreboard queue; a negedge monitor checks the DUT outputs against it.
module tb_key_pulse_gen;

    localparam int DEB  = 4;
    localparam int PLEN = 3;

    logic       clk = 1'b0;
    logic       rd = 1'b0;
    logic       key_in = 1'b0;
    logic       x;
    logic       press_pulse;
    logic       key_state;
    logic [7:0] press_cnt;

    key_pulse_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .PULSE_LEN       (PLEN),
        .CNT_W           (4)
    ) dut (
        .clk         (clk),
        .rd          (rd),
        .key_in      (key_in),
        .x           (x),
        .press_pulse (press_pulse),
        .key_state   (key_state),
        .press_cnt   (press_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int cnt;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_on = 1'b0;

    // reference model state: two-stage input delay, debounced level, streak length
    int m_s1 = 0, m_s2 = 0, m_lvl = 0, m_run = 0, m_tmr = 0, m_cnt = 0;

    // monitor observations
    int dut_pulses = 0, dut_falls = 0, low_run = 0, last_width = 0;
    int last_pulse_cyc = -1, last_fall_cyc = -1;
    logic prev_x = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, advance the model on the rising edge
    task automatic step(input logic k, input logic r);
        int ks;
        @(negedge clk);
        key_in = k;
        rd     = r;
        @(posedge clk);
        cyc++;
        if (!r) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_tmr = 0; m_cnt = 0;
        end else begin
            ks   = m_s2;
            m_s2 = m_s1;
            m_s1 = int'(k);
            if (m_tmr > 0) m_tmr--;
            if (ks != m_lvl) begin
                m_run++;
                if (m_run == DEB) begin
                    m_lvl = ks;
                    m_run = 0;
                    if (ks == 1) begin
                        m_tmr = PLEN;
                        m_cnt = (m_cnt + 1) % 256;
                        exp_q.push_back('{cyc: cyc, cnt: m_cnt});
                    end
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic hold(input logic k, input int n);
        for (int i = 0; i < n; i++) step(k, 1'b1);
    endtask

    task automatic press();
        hold(1'b1, 8);
        hold(1'b0, 8);
    endtask

    // Monitor: per-cycle output checks and scoreboard pops on press_pulse
    always @(negedge clk) begin
        if (mon_on) begin
            chk("x_level", int'(x), (m_tmr == 0) ? 1 : 0);
            chk("key_state", int'(key_state), m_lvl);
            chk("press_cnt", int'(press_cnt), m_cnt);
            if (press_pulse) begin
                dut_pulses++;
                last_pulse_cyc = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_cycle", cyc, mon_e.cyc);
                    chk("pulse_cnt", int'(press_cnt), mon_e.cnt);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                chk("missed_pulse_cycle", cyc, mon_e.cyc);
            end
            if (prev_x && !x) begin
                dut_falls++;
                last_fall_cyc = cyc;
            end
            if (!x) begin
                low_run++;
            end else if (!prev_x) begin
                last_width = low_run;
                low_run    = 0;
            end
            prev_x = x;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, p0, f0, found;
        // 1: reset held with key pressed
        step(1'b1, 1'b0);
        mon_on = 1'b1;
        step(1'b1, 1'b0);
        #1;
        chk("t1_x", int'(x), 1);
        chk("t1_pulse", int'(press_pulse), 0);
        chk("t1_key_state", int'(key_state), 0);
        chk("t1_press_cnt", int'(press_cnt), 0);

        // 2: clean hold for 20 cycles
        hold(1'b0, 2);
        p0 = dut_pulses;
        step(1'b1, 1'b1);
        c0 = cyc;
        hold(1'b1, 19);
        #1;
        chk("t2_latency", last_pulse_cyc - c0 + 1, 6);
        chk("t2_x_fall_with_pulse", last_fall_cyc, last_pulse_cyc);
        chk("t2_x_low_width", last_width, PLEN);
        chk("t2_press_cnt", int'(press_cnt), 1);
        chk("t2_pulse_count", dut_pulses - p0, 1);
        hold(1'b0, 8);

        // 3: bounce pattern, only the final stable run is accepted
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        p0 = dut_pulses;
        hold(1'b1, 1); hold(1'b0, 1); hold(1'b1, 2); hold(1'b0, 1); hold(1'b1, 5);
        hold(1'b1, 4);
        #1;
        chk("t3_pulse_count", dut_pulses - p0, 1);
        chk("t3_press_cnt", int'(press_cnt), 1);

        // 4: release glitch while held, then true release
        p0 = dut_pulses;
        hold(1'b0, 2);
        hold(1'b1, 6);
        #1;
        chk("t4_key_state_held", int'(key_state), 1);
        chk("t4_no_new_accept", dut_pulses - p0, 0);
        hold(1'b0, 8);
        #1;
        chk("t4_key_state_released", int'(key_state), 0);

        // 5: 256 presses wrap the counter
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        f0 = dut_falls;
        for (int i = 0; i < 256; i++) press();
        #1;
        chk("t5_press_cnt_wrap", int'(press_cnt), 0);
        chk("t5_x_falls", dut_falls - f0, 256);

        // 6: reset during the x low window
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step(1'b1, 1'b1);
            if (m_tmr == PLEN) found = 1;
        end
        chk("t6_accept_seen", found, 1);
        step(1'b1, 1'b1);
        #1;
        chk("t6_x_low_before_reset", int'(x), 0);
        step(1'b1, 1'b0);
        #1;
        chk("t6_x_after_reset", int'(x), 1);
        chk("t6_press_cnt_after_reset", int'(press_cnt), 0);
        hold(1'b0, 4);
        press();
        #1;
        chk("t6_full_width", last_width, PLEN);
        chk("t6_press_cnt", int'(press_cnt), 1);

        // Randomized bouncing key
        for (int s = 0; s < 80; s++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            hold(lvl, len);
        end
        hold(1'b0, 10);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
